// File: rtl/axi_sft_tmr_addr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_sft_tmr_addr_arbiter
//
// Shares one crossbar master address port between S_COUNT slave-side address
// decoders. A grant is held until the address handshake completes. The
// arbitration state (FSM state, grant index, round-robin pointer) lives in
// three replicas. Every cycle they are majority-voted, and all three replicas
// reload the next state computed from the vote, so a single upset is scrubbed
// within one cycle. Any disagreement is reported as a pulse and counted.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   s_req_valid     per-slave request, held until accepted
//   s_req_qos       per-slave aqos, slave i on bits [4i+3:4i]
//   s_req_ready     per-slave accept (combinational from m_ready)
//   m_valid         address valid toward the master port
//   m_ready         master port accept
//   m_grant_idx     index of the granted slave (mux select)
//   m_grant_onehot  one-hot of m_grant_idx, zero while m_valid is low
//   tmr_err_pulse   one-cycle pulse after a replica disagreed with the vote
//   tmr_err_count   saturating count of disagreement cycles
//   tmr_err_clr     synchronous clear of tmr_err_count (wins over increment)
// ---------------------------------------------------------------------------
module axi_sft_tmr_addr_arbiter #(
  parameter int S_COUNT       = 4,
  parameter int ARB_QOS       = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [S_COUNT-1:0]         s_req_valid,
  input  logic [4*S_COUNT-1:0]       s_req_qos,
  output logic [S_COUNT-1:0]         s_req_ready,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(S_COUNT)-1:0] m_grant_idx,
  output logic [S_COUNT-1:0]         m_grant_onehot,
  output logic                       tmr_err_pulse,
  output logic [ERR_CNT_WIDTH-1:0]   tmr_err_count,
  input  logic                       tmr_err_clr
);

  localparam int IDX_W = $clog2(S_COUNT);
  localparam logic [IDX_W-1:0]         PTR_RST  = IDX_W'(S_COUNT - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ZERO = {ERR_CNT_WIDTH{1'b0}};
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE  = ERR_CNT_WIDTH'(1'b1);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX  = {ERR_CNT_WIDTH{1'b1}};
  localparam logic [S_COUNT-1:0]       REQ_ZERO = {S_COUNT{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Bitwise 2-of-3 majority of a single bit.
  function automatic logic vote_bit(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Bitwise 2-of-3 majority of an index-wide field.
  function automatic logic [IDX_W-1:0] vote_idx(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b,
                                                input logic [IDX_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Returns {found, winner}. With QoS enabled only the candidates carrying the
  // highest aqos stay eligible; the winner is the first eligible slave found
  // when walking ptr+1, ptr+2, ... modulo S_COUNT.
  function automatic logic [IDX_W:0] arb_pick(input logic [S_COUNT-1:0]   cand,
                                              input logic [4*S_COUNT-1:0] qos,
                                              input logic [IDX_W-1:0]     ptr);
    logic [3:0]         max_q;
    logic [S_COUNT-1:0] elig;
    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W:0]     pos;
    max_q = 4'd0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (cand[i] && (qos[4*i +: 4] > max_q)) max_q = qos[4*i +: 4];
      else                                    max_q = max_q;
    end
    elig = cand;
    for (int i = 0; i < S_COUNT; i++) begin
      if ((ARB_QOS != 0) && (qos[4*i +: 4] != max_q)) elig[i] = 1'b0;
      else                                            elig[i] = cand[i];
    end
    found = 1'b0;
    win   = {IDX_W{1'b0}};
    for (int k = 1; k <= S_COUNT; k++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(S_COUNT)) pos = pos - (IDX_W+1)'(S_COUNT);
      else                            pos = pos;
      if (!found && elig[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = pos[IDX_W-1:0];
      end else begin
        found = found;
      end
    end
    return {found, win};
  endfunction

  // Three replicas of the arbitration state
  state_e           state0_q, state1_q, state2_q;
  logic [IDX_W-1:0] grant0_q, grant1_q, grant2_q;
  logic [IDX_W-1:0] ptr0_q,   ptr1_q,   ptr2_q;

  state_e           state_vote_s, state_d;
  logic [IDX_W-1:0] grant_vote_s, grant_d;
  logic [IDX_W-1:0] ptr_vote_s,   ptr_d;
  logic             mismatch_s;

  logic [S_COUNT-1:0] grant_oh_s;
  logic [S_COUNT-1:0] cand_s;
  logic [IDX_W-1:0]   arb_ptr_s;
  logic [IDX_W:0]     pick_s;
  logic               win_found_s;
  logic [IDX_W-1:0]   win_idx_s;

  logic                     err_pulse_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  // Majority vote of the replicas and detection of any dissenting replica.
  always_comb begin
    state_vote_s = state_e'(vote_bit(state0_q, state1_q, state2_q));
    grant_vote_s = vote_idx(grant0_q, grant1_q, grant2_q);
    ptr_vote_s   = vote_idx(ptr0_q, ptr1_q, ptr2_q);
    mismatch_s   = (state0_q != state_vote_s) | (grant0_q != grant_vote_s) | (ptr0_q != ptr_vote_s) |
                   (state1_q != state_vote_s) | (grant1_q != grant_vote_s) | (ptr1_q != ptr_vote_s) |
                   (state2_q != state_vote_s) | (grant2_q != grant_vote_s) | (ptr2_q != ptr_vote_s);
  end

  // One-hot decode of the voted grant index.
  always_comb begin
    grant_oh_s = REQ_ZERO;
    for (int i = 0; i < S_COUNT; i++) begin
      grant_oh_s[i] = (grant_vote_s == IDX_W'(i));
    end
  end

  // Arbitration inputs: while granted the current owner is excluded and the
  // search starts after it, so the re-arbitration on a handshake already sees
  // the pointer value that the handshake is about to commit.
  always_comb begin
    cand_s    = s_req_valid;
    arb_ptr_s = ptr_vote_s;
    if (state_vote_s == ST_GRANT) begin
      cand_s    = s_req_valid & ~grant_oh_s;
      arb_ptr_s = grant_vote_s;
    end else begin
      cand_s    = s_req_valid;
      arb_ptr_s = ptr_vote_s;
    end
    pick_s      = arb_pick(cand_s, s_req_qos, arb_ptr_s);
    win_found_s = pick_s[IDX_W];
    win_idx_s   = pick_s[IDX_W-1:0];
  end

  // Next-state logic, evaluated on the voted state only.
  always_comb begin
    state_d = state_vote_s;
    grant_d = grant_vote_s;
    ptr_d   = ptr_vote_s;
    case (state_vote_s)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d = ST_GRANT;
          grant_d = win_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // Without a handshake the grant is frozen: no preemption, and a
        // requester dropping valid does not release it.
        if (m_ready) begin
          ptr_d = grant_vote_s;
          if (win_found_s) begin
            state_d = ST_GRANT;
            grant_d = win_idx_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Replica registers; all three reload the voted next state (scrubbing).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state0_q <= ST_IDLE;
      state1_q <= ST_IDLE;
      state2_q <= ST_IDLE;
      grant0_q <= {IDX_W{1'b0}};
      grant1_q <= {IDX_W{1'b0}};
      grant2_q <= {IDX_W{1'b0}};
      ptr0_q   <= PTR_RST;
      ptr1_q   <= PTR_RST;
      ptr2_q   <= PTR_RST;
    end else begin
      state0_q <= state_d;
      state1_q <= state_d;
      state2_q <= state_d;
      grant0_q <= grant_d;
      grant1_q <= grant_d;
      grant2_q <= grant_d;
      ptr0_q   <= ptr_d;
      ptr1_q   <= ptr_d;
      ptr2_q   <= ptr_d;
    end
  end

  // Upset pulse and saturating upset counter; clear beats a same-cycle upset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      err_cnt_q   <= CNT_ZERO;
    end else begin
      err_pulse_q <= mismatch_s;
      if (tmr_err_clr) begin
        err_cnt_q <= CNT_ZERO;
      end else if (mismatch_s && (err_cnt_q != CNT_MAX)) begin
        err_cnt_q <= err_cnt_q + CNT_ONE;
      end else begin
        err_cnt_q <= err_cnt_q;
      end
    end
  end

  // Outputs are decoded from voted state; ready follows m_ready directly.
  always_comb begin
    m_valid        = (state_vote_s == ST_GRANT);
    m_grant_idx    = grant_vote_s;
    m_grant_onehot = m_valid ? grant_oh_s : REQ_ZERO;
    s_req_ready    = (m_valid && m_ready) ? grant_oh_s : REQ_ZERO;
    tmr_err_pulse  = err_pulse_q;
    tmr_err_count  = err_cnt_q;
  end

endmodule

// File: tb/tb_axi_sft_tmr_addr_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for axi_sft_tmr_addr_arbiter (S_COUNT=4, QoS on, 8-bit counter).
// Directed scenarios plus a randomized run checked against a cycle-level
// reference model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_axi_sft_tmr_addr_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  s_req_valid;
  logic [4*N-1:0] s_req_qos;
  logic [N-1:0]  s_req_ready;
  logic          m_valid;
  logic          m_ready;
  logic [1:0]    m_grant_idx;
  logic [N-1:0]  m_grant_onehot;
  logic          tmr_err_pulse;
  logic [7:0]    tmr_err_count;
  logic          tmr_err_clr;

  int n_cmp;
  int n_bad;

  // reference model: busy flag, current grant, last served slave
  bit mdl_busy;
  int mdl_grant;
  int mdl_last;

  logic [1:0] flip_val;
  logic [1:0] fix_val;

  axi_sft_tmr_addr_arbiter #(
    .S_COUNT      (N),
    .ARB_QOS      (1),
    .ERR_CNT_WIDTH(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_req_valid   (s_req_valid),
    .s_req_qos     (s_req_qos),
    .s_req_ready   (s_req_ready),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_grant_idx   (m_grant_idx),
    .m_grant_onehot(m_grant_onehot),
    .tmr_err_pulse (tmr_err_pulse),
    .tmr_err_count (tmr_err_count),
    .tmr_err_clr   (tmr_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Highest qos wins; ties go to the first slave after 'last' in circular order.
  function automatic int pick(input logic [N-1:0] v, input logic [4*N-1:0] q,
                              input int last, input int excl);
    int best, bestq, j, qj;
    logic [4*N-1:0] sh;
    best  = -1;
    bestq = -1;
    for (int off = 1; off <= N; off++) begin
      j  = (last + off) % N;
      sh = q >> (4 * j);
      qj = int'(sh[3:0]);
      if (v[j[1:0]] && (j != excl) && (qj > bestq)) begin
        best  = j;
        bestq = qj;
      end
    end
    return best;
  endfunction

  task automatic model_edge();
    int w;
    if (!rst_n) begin
      mdl_busy  = 1'b0;
      mdl_grant = 0;
      mdl_last  = N - 1;
    end else if (!mdl_busy) begin
      w = pick(s_req_valid, s_req_qos, mdl_last, -1);
      if (w >= 0) begin
        mdl_busy  = 1'b1;
        mdl_grant = w;
      end
    end else if (m_ready) begin
      mdl_last = mdl_grant;
      w = pick(s_req_valid, s_req_qos, mdl_last, mdl_grant);
      if (w >= 0) mdl_grant = w;
      else        mdl_busy  = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply(input logic [N-1:0] v, input logic [4*N-1:0] q, input logic rdy);
    s_req_valid = v;
    s_req_qos   = q;
    m_ready     = rdy;
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    s_req_valid = 4'b0000;
    s_req_qos   = 16'h0000;
    m_ready     = 1'b0;
    tmr_err_clr = 1'b0;
    mdl_busy    = 1'b0;
    mdl_grant   = 0;
    mdl_last    = N - 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic inject_start(input logic clr);
    flip_val = dut.grant1_q ^ 2'b01;
    force dut.grant1_q = flip_val;
    tmr_err_clr = clr;
    #1;
  endtask

  task automatic inject_end();
    fix_val = dut.grant0_q;
    force dut.grant1_q = fix_val;
    #1;
    release dut.grant1_q;
    tmr_err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    s_req_valid = 4'b1111;
    s_req_qos   = 16'h0000;
    m_ready     = 1'b1;
    tmr_err_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_m_valid: got %b expected 0", m_valid);
    end
    n_cmp++;
    if (m_grant_idx !== 2'd0) begin
      n_bad++; $display("FAIL reset_grant_idx: got %0d expected 0", m_grant_idx);
    end
    n_cmp++;
    if ({m_grant_onehot, s_req_ready} !== 8'h00) begin
      n_bad++; $display("FAIL reset_onehot_ready: got %b/%b expected 0000/0000", m_grant_onehot, s_req_ready);
    end
    n_cmp++;
    if ({tmr_err_pulse, tmr_err_count} !== 9'd0) begin
      n_bad++; $display("FAIL reset_err: got pulse %b count %0d expected 0/0", tmr_err_pulse, tmr_err_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    apply(4'b0010, 16'h0000, 1'b1);
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_latency: got m_valid %b expected 0", m_valid);
    end
    tick();
    n_cmp++;
    if ({m_valid, m_grant_idx, m_grant_onehot, s_req_ready} !== {1'b1, 2'd1, 4'b0010, 4'b0010}) begin
      n_bad++; $display("FAIL single_grant: got v%b idx%0d oh%b rdy%b expected v1 idx1 oh0010 rdy0010",
                        m_valid, m_grant_idx, m_grant_onehot, s_req_ready);
    end
    tick();
    apply(4'b0000, 16'h0000, 1'b1);
    n_cmp++;
    if ({m_valid, s_req_ready} !== 5'b0_0000) begin
      n_bad++; $display("FAIL single_idle: got v%b rdy%b expected v0 rdy0000", m_valid, s_req_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] oh;
    do_reset();
    apply(4'b1111, 16'h0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      oh = 4'b0001 << (k % N);
      n_cmp++;
      if ({m_valid, int'(m_grant_idx), s_req_ready} !== {1'b1, k % N, oh}) begin
        n_bad++; $display("FAIL rr_step%0d: got v%b idx%0d rdy%b expected v1 idx%0d rdy%b",
                          k, m_valid, m_grant_idx, s_req_ready, k % N, oh);
      end
    end
  endtask

  task automatic test_qos_priority();
    int exp_seq [3] = '{3, 0, 1};
    do_reset();
    apply(4'b1111, 16'h0F00, 1'b1);
    tick();
    n_cmp++;
    if ({m_valid, m_grant_idx, s_req_ready} !== {1'b1, 2'd2, 4'b0100}) begin
      n_bad++; $display("FAIL qos_first: got v%b idx%0d rdy%b expected v1 idx2 rdy0100",
                        m_valid, m_grant_idx, s_req_ready);
    end
    tick();
    apply(4'b1011, 16'h0F00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (int'(m_grant_idx) !== exp_seq[k] || m_valid !== 1'b1) begin
        n_bad++; $display("FAIL qos_after%0d: got v%b idx%0d expected v1 idx%0d",
                          k, m_valid, m_grant_idx, exp_seq[k]);
      end
      tick();
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    apply(4'b1000, 16'h0000, 1'b0);
    tick();
    apply(4'b1001, 16'h000F, 1'b0);
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if ({m_valid, m_grant_idx, m_grant_onehot, s_req_ready} !== {1'b1, 2'd3, 4'b1000, 4'b0000}) begin
        n_bad++; $display("FAIL hold_cycle%0d: got v%b idx%0d oh%b rdy%b expected v1 idx3 oh1000 rdy0000",
                          k, m_valid, m_grant_idx, m_grant_onehot, s_req_ready);
      end
      tick();
    end
    apply(4'b1001, 16'h000F, 1'b1);
    n_cmp++;
    if (s_req_ready !== 4'b1000) begin
      n_bad++; $display("FAIL hold_release_ready: got %b expected 1000", s_req_ready);
    end
    tick();
    n_cmp++;
    if ({m_valid, m_grant_idx} !== {1'b1, 2'd0}) begin
      n_bad++; $display("FAIL hold_next: got v%b idx%0d expected v1 idx0", m_valid, m_grant_idx);
    end
  endtask

  task automatic test_random();
    logic [N-1:0]   v, acc, exp_oh, exp_rdy;
    logic [4*N-1:0] q;
    logic           rdy;
    do_reset();
    v   = 4'b0000;
    q   = 16'h0000;
    acc = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i]) v[i] = 1'b0;
        if (!v[i] && ($urandom_range(0, 2) == 0)) begin
          v[i] = 1'b1;
          q[4*i +: 4] = 4'($urandom_range(0, 3));
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      apply(v, q, rdy);
      exp_oh  = mdl_busy ? (4'b0001 << mdl_grant) : 4'b0000;
      exp_rdy = rdy ? exp_oh : 4'b0000;
      n_cmp++;
      if (m_valid !== mdl_busy || int'(m_grant_idx) !== mdl_grant ||
          m_grant_onehot !== exp_oh || s_req_ready !== exp_rdy) begin
        n_bad++; $display("FAIL random_cycle%0d: got v%b idx%0d oh%b rdy%b expected v%b idx%0d oh%b rdy%b",
                          c, m_valid, m_grant_idx, m_grant_onehot, s_req_ready,
                          mdl_busy, mdl_grant, exp_oh, exp_rdy);
      end
      acc = exp_rdy;
      tick();
    end
  endtask

  task automatic test_tmr_upset();
    do_reset();
    apply(4'b0100, 16'h0000, 1'b0);
    tick();
    inject_start(1'b0);
    n_cmp++;
    if ({m_valid, m_grant_idx, m_grant_onehot, tmr_err_pulse} !== {1'b1, 2'd2, 4'b0100, 1'b0}) begin
      n_bad++; $display("FAIL upset_masked: got v%b idx%0d oh%b pulse%b expected v1 idx2 oh0100 pulse0",
                        m_valid, m_grant_idx, m_grant_onehot, tmr_err_pulse);
    end
    tick();
    inject_end();
    n_cmp++;
    if ({tmr_err_pulse, tmr_err_count, m_grant_idx} !== {1'b1, 8'd1, 2'd2}) begin
      n_bad++; $display("FAIL upset_report: got pulse%b count%0d idx%0d expected pulse1 count1 idx2",
                        tmr_err_pulse, tmr_err_count, m_grant_idx);
    end
    tick();
    n_cmp++;
    if ({tmr_err_pulse, tmr_err_count} !== {1'b0, 8'd1}) begin
      n_bad++; $display("FAIL upset_scrubbed: got pulse%b count%0d expected pulse0 count1",
                        tmr_err_pulse, tmr_err_count);
    end
    for (int k = 0; k < 254; k++) begin
      inject_start(1'b0);
      tick();
      inject_end();
    end
    n_cmp++;
    if (tmr_err_count !== 8'hFF) begin
      n_bad++; $display("FAIL count_reach_max: got %h expected ff", tmr_err_count);
    end
    inject_start(1'b0);
    tick();
    inject_end();
    n_cmp++;
    if ({tmr_err_pulse, tmr_err_count} !== {1'b1, 8'hFF}) begin
      n_bad++; $display("FAIL count_saturate: got pulse%b count%h expected pulse1 countff",
                        tmr_err_pulse, tmr_err_count);
    end
    inject_start(1'b1);
    tick();
    inject_end();
    n_cmp++;
    if ({tmr_err_pulse, tmr_err_count} !== {1'b1, 8'h00}) begin
      n_bad++; $display("FAIL clear_wins: got pulse%b count%h expected pulse1 count00",
                        tmr_err_pulse, tmr_err_count);
    end
    tick();
    n_cmp++;
    if ({tmr_err_pulse, tmr_err_count, m_valid, m_grant_idx} !== {1'b0, 8'h00, 1'b1, 2'd2}) begin
      n_bad++; $display("FAIL after_clear: got pulse%b count%h v%b idx%0d expected pulse0 count00 v1 idx2",
                        tmr_err_pulse, tmr_err_count, m_valid, m_grant_idx);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    apply(4'b0110, 16'h0000, 1'b0);
    tick();
    inject_start(1'b0);
    tick();
    inject_end();
    m_ready = 1'b1;
    #1;
    n_cmp++;
    if ({m_valid, m_grant_idx, s_req_ready, tmr_err_count} !== {1'b1, 2'd1, 4'b0010, 8'd1}) begin
      n_bad++; $display("FAIL midrst_pre: got v%b idx%0d rdy%b count%0d expected v1 idx1 rdy0010 count1",
                        m_valid, m_grant_idx, s_req_ready, tmr_err_count);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_valid, m_grant_onehot, s_req_ready, tmr_err_count} !== {1'b0, 4'b0000, 4'b0000, 8'd0}) begin
      n_bad++; $display("FAIL midrst_async: got v%b oh%b rdy%b count%0d expected v0 oh0000 rdy0000 count0",
                        m_valid, m_grant_onehot, s_req_ready, tmr_err_count);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    mdl_busy  = 1'b0;
    mdl_grant = 0;
    mdl_last  = N - 1;
    apply(4'b1111, 16'h0000, 1'b0);
    tick();
    n_cmp++;
    if ({m_valid, m_grant_idx} !== {1'b1, 2'd0}) begin
      n_bad++; $display("FAIL midrst_first_tie: got v%b idx%0d expected v1 idx0", m_valid, m_grant_idx);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_qos_priority();
    test_no_preempt();
    test_random();
    test_tmr_upset();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
